// File: rtl/dma_defs.sv
// Shared definitions for the DMA copy engine: state encoding and default width.
package dma_defs;

    localparam int DMA_WIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } dma_state_e;

endpackage

// File: rtl/dma_copy_engine.sv
// Block copy engine for data_mem: read one word, write it, advance, 2 cycles/word.
// Optional DMA_CHECKSUM_EN adds a running sum of the copied words.
module dma_copy_engine
    import dma_defs::*;
#(
    parameter int WIDTH = DMA_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_src_addr,
    input  logic [WIDTH-1:0] i_dst_addr,
    input  logic [WIDTH-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_aborted,
    output logic [WIDTH-1:0] o_checksum,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic             o_mem_write_en,
    output logic [WIDTH-1:0] o_mem_write_data,
    input  logic [WIDTH-1:0] i_mem_read_data
);

    dma_state_e       r_state, w_next;
    logic [WIDTH-1:0] r_src, r_dst, r_cnt, r_buf;
    logic             r_aborted, r_abort_req;
    logic             w_launch, w_stop;

    assign w_launch = (r_state == S_IDLE) && i_start;
    // An abort seen in RD or in WR ends the copy after the WR in flight.
    assign w_stop   = (r_cnt == WIDTH'(1)) || r_abort_req || i_abort;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next = (i_len == '0) ? S_FIN : S_RD;
            S_RD:   w_next = S_WR;
            S_WR:   w_next = w_stop ? S_FIN : S_RD;
            S_FIN:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_aborted   <= 1'b0;
            r_abort_req <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_src       <= i_src_addr;
                    r_dst       <= i_dst_addr;
                    r_cnt       <= i_len;
                    r_aborted   <= 1'b0;
                    r_abort_req <= 1'b0;
                end
                S_RD: begin
                    r_buf <= i_mem_read_data;
                    if (i_abort) r_abort_req <= 1'b1;
                end
                S_WR: begin
                    r_src       <= r_src + WIDTH'(1);
                    r_dst       <= r_dst + WIDTH'(1);
                    r_cnt       <= r_cnt - WIDTH'(1);
                    r_abort_req <= 1'b0;
                    if (r_abort_req || i_abort) r_aborted <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef DMA_CHECKSUM_EN
    logic [WIDTH-1:0] r_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                r_sum <= '0;
        else if (w_launch)           r_sum <= '0;
        else if (r_state == S_WR)    r_sum <= r_sum + r_buf;
    end

    assign o_checksum = r_sum;
`else
    assign o_checksum = '0;
`endif

    // Decoded straight from the state register so reset drops write_en at once.
    assign o_busy           = (r_state == S_RD) || (r_state == S_WR);
    assign o_done           = (r_state == S_FIN);
    assign o_aborted        = r_aborted;
    assign o_mem_write_en   = (r_state == S_WR);
    assign o_mem_addr       = (r_state == S_WR) ? r_dst :
                              (r_state == S_RD) ? r_src : '0;
    assign o_mem_write_data = (r_state == S_WR) ? r_buf : '0;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Self-checking bench for dma_copy_engine with a 256-word data_mem model.
module tb_dma_copy_engine;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [15:0] src_addr = '0, dst_addr = '0, len = '0;
    logic        busy, done, aborted, mem_write_en;
    logic [15:0] checksum, mem_addr, mem_write_data, mem_read_data;

    dma_copy_engine #(.WIDTH(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_src_addr(src_addr), .i_dst_addr(dst_addr), .i_len(len),
        .o_busy(busy), .o_done(done), .o_aborted(aborted), .o_checksum(checksum),
        .o_mem_addr(mem_addr), .o_mem_write_en(mem_write_en),
        .o_mem_write_data(mem_write_data), .i_mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // data_mem model: combinational read, clocked write; bench back-door port when DUT idle
    logic [15:0] mem [256];
    logic        tb_we = 1'b0;
    logic [7:0]  tb_wa = '0;
    logic [15:0] tb_wd = '0;
    assign mem_read_data = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr[7:0]] <= mem_write_data;
        else if (tb_we)   mem[tb_wa] <= tb_wd;
    end

    // cumulative bus monitor
    int          mon_wr = 0, mon_leak = 0, mon_busy = 0;
    logic [15:0] rd_q[$], wr_q[$];
    always @(negedge clk) begin
        if (mem_write_en) begin mon_wr++; wr_q.push_back(mem_addr); end
        if (mem_write_en && !busy) mon_leak++;
        if (busy) mon_busy++;
        if (busy && !mem_write_en) rd_q.push_back(mem_addr);
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    // Model: ascending word-by-word copy (so overlap replicates), truncated by abort.
    task automatic do_copy(input string tag, input logic [15:0] s, input logic [15:0] d,
                           input logic [15:0] l, input int abort_rd, input bit poke_start);
        logic [15:0] em [256];
        logic [15:0] a, b, v, sum;
        int k, n, diffs, wr0, busy0;
        bit exp_ab;
        for (int i = 0; i < 256; i++) em[i] = mem[i];
        exp_ab = (abort_rd > 0) && (abort_rd <= int'(l));
        k = (abort_rd > 0 && abort_rd < int'(l)) ? abort_rd : int'(l);
        sum = '0;
        for (int i = 0; i < k; i++) begin
            a = s + 16'(i); b = d + 16'(i);
            v = em[a[7:0]];
            em[b[7:0]] = v;
            sum = sum + v;
        end
        wr0 = mon_wr; busy0 = mon_busy;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 2;
        while (!done) begin
            if (n == 2 * abort_rd) abort = 1'b1;
            if (poke_start && n == 2) begin start = 1'b1; src_addr = ~s; len = 16'd7; end
            @(posedge clk); #1;
            abort = 1'b0; start = 1'b0; src_addr = s; len = l;
            n++;
            if (n > 2 * int'(l) + 8) break;
        end
        chk({tag, " done/latency"}, done ? n : -1, 2 * k + 2);
        chk({tag, " aborted"}, aborted, exp_ab);
`ifdef DMA_CHECKSUM_EN
        chk({tag, " checksum"}, checksum, sum);
`else
        chk({tag, " checksum"}, checksum, 16'h0);
`endif
        chk({tag, " writes"}, mon_wr - wr0, k);
        if (l == 0) chk({tag, " busy cycles"}, mon_busy - busy0, 0);
        @(posedge clk); #1;
        chk({tag, " done pulse/idle"}, {done, busy}, 2'b00);
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== em[i]) diffs++;
        chk({tag, " memory diffs"}, diffs, 0);
        chk({tag, " write_en leak"}, mon_leak, 0);
    endtask

    initial begin
        int rb, wb, l, ab;
        logic [15:0] m50, m61;
        #2;
        chk("reset outputs", {busy, done, aborted, mem_write_en}, 4'b0);
        chk("reset addr/data/sum", {mem_addr, mem_write_data}, 32'h0);
        chk("reset checksum", checksum, 16'h0);
        for (int i = 0; i < 256; i++) poke(8'(i), 16'($urandom));
        @(negedge clk) rst_n = 1'b1;

        // 1: basic 4-word copy
        for (int i = 0; i < 4; i++) poke(8'(8'h10 + i), 16'(i + 1));
        do_copy("t1", 16'h0010, 16'h0040, 16'd4, 0, 0);
        chk("t1 mem[0x43]", mem[8'h43], 16'h0004);
`ifdef DMA_CHECKSUM_EN
        chk("t1 checksum const", checksum, 16'h000A);
`endif

        // 2: zero length
        do_copy("t2", 16'h0010, 16'h0050, 16'd0, 0, 0);

        // 3: source pointer wrap
        rb = rd_q.size(); wb = wr_q.size();
        do_copy("t3", 16'hFFFF, 16'h0020, 16'd2, 0, 0);
        chk("t3 read addrs", {rd_q[rb], rd_q[rb+1]}, 32'hFFFF_0000);
        chk("t3 write addrs", {wr_q[wb], wr_q[wb+1]}, 32'h0020_0021);

        // 4: abort during 3rd RD of 8
        do_copy("t4", 16'h0080, 16'h00A0, 16'd8, 3, 0);

        // 5: overlapping forward copy replicates the head
        poke(8'h10, 16'hAAAA);
        do_copy("t5", 16'h0010, 16'h0011, 16'd3, 0, 0);
        chk("t5 mem[0x13]", mem[8'h13], 16'hAAAA);

        // 6: async reset during 2nd WR of 5, then normal copy with a stray start
        m50 = mem[8'h50]; m61 = mem[8'h61];
        @(negedge clk);
        src_addr = 16'h0050; dst_addr = 16'h0060; len = 16'd5; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6 reset busy/we", {busy, mem_write_en, done}, 3'b000);
        chk("t6 reset checksum", checksum, 16'h0);
        @(negedge clk) rst_n = 1'b1;
        chk("t6 word1 written", mem[8'h60], m50);
        chk("t6 word2 not written", mem[8'h61], m61);
        do_copy("t6b", 16'h0070, 16'h0080, 16'd1, 0, 1);
        repeat (3) @(posedge clk);
        #1 chk("t6b stays idle", busy, 1'b0);

        // randomized copies, some aborted
        for (int t = 0; t < 8; t++) begin
            l = $urandom_range(0, 12);
            ab = (l > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, l) : 0;
            do_copy("rnd", 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                    16'(l), ab, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
